stream_computer: RTL and testbench

//  Parametrised successor to the fixed 8-bit/4-word computer: executor FSM + register memory in one core.

---
 rtl/stream_computer_pkg.sv | 48 ++++
 rtl/stream_computer_reg_memory.sv | 49 ++++
 rtl/stream_computer.sv | 202 ++++++++++++++++++++
 tb/tb_stream_computer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_computer_pkg.sv
// Shared types and opcode field layout for the stream_computer core.
// Opcode layout (MSB..LSB): {op[2:0], dst[M-1:0], srcA[M-1:0], srcB[M-1:0], imm[N-1:0]}.
package stream_computer_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOADI = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_AND   = 3'd4,
    OP_OR    = 3'd5,
    OP_XOR   = 3'd6,
    OP_SHL   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WR   = 3'd4
  } state_e;

  function automatic int op_width(input int n, input int m);
    return 3 + 3 * m + n;
  endfunction

  function automatic int imm_lsb(input int n, input int m);
    return 0 * (n + m);
  endfunction

  function automatic int srcb_lsb(input int n, input int m);
    return n + 0 * m;
  endfunction

  function automatic int srca_lsb(input int n, input int m);
    return n + m;
  endfunction

  function automatic int dst_lsb(input int n, input int m);
    return n + 2 * m;
  endfunction

  function automatic int op_lsb(input int n, input int m);
    return n + 3 * m;
  endfunction

endpackage

// File: rtl/stream_computer_reg_memory.sv
// Register memory for stream_computer: COUNT = 2**M words of N bits,
// asynchronous clear, one synchronous read port, one write port and one
// combinational peek port for debug.
module reg_memory
  import stream_computer_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [M-1:0] rd_addr_i,
  output logic [N-1:0] rd_data_o,
  input  logic         we_i,
  input  logic [M-1:0] wr_addr_i,
  input  logic [N-1:0] wr_data_i,
  input  logic [M-1:0] peek_addr_i,
  output logic [N-1:0] peek_data_o
);

  localparam int COUNT = 2 ** M;

  logic [N-1:0] mem_q [COUNT];
  logic [N-1:0] rd_data_q;

  // Storage array: cleared on reset, written on the write strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < COUNT; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Synchronous read port: data appears the cycle after the address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o   = rd_data_q;
  assign peek_data_o = mem_q[peek_addr_i];

endmodule

// File: rtl/stream_computer.sv
// stream_computer: opcode stream executor with a single-port register memory.
// Each opcode runs IDLE -> RD_A -> RD_B -> EXEC -> WR (LOADI jumps IDLE -> WR,
// NOP and illegal ops retire directly from IDLE).
// Build option: define COMPUTER_SHIFT_EN to enable op 7 (SHL); otherwise op 7
// is treated as illegal and no shifter is built.
module stream_computer
  import stream_computer_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int M    = 2,
  localparam int OP_W = 3 + 3 * M + N
) (
  input  logic            Clock,
  input  logic            ResetN,
  input  logic            OpValid,
  output logic            OpReady,
  input  logic [OP_W-1:0] OpCode,
  output logic            Done,
  output logic            Error,
  output logic [N-1:0]    Result,
  output logic            Zero,
  output logic            Carry,
  input  logic [M-1:0]    PeekAddr,
  output logic [N-1:0]    PeekData
);

  localparam int OP_LSB   = op_lsb(N, M);
  localparam int DST_LSB  = dst_lsb(N, M);
  localparam int SRCA_LSB = srca_lsb(N, M);
  localparam int SRCB_LSB = srcb_lsb(N, M);
  localparam int IMM_LSB  = imm_lsb(N, M);

  state_e       state_q, state_d;
  logic         done_q, done_d;
  logic         error_q, error_d;
  logic [N-1:0] result_q, result_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic         accept;

  op_e          op_in;
  op_e          op_q;
  logic [M-1:0] dst_q, srca_q, srcb_q;
  logic [N-1:0] imm_q;
  logic [N-1:0] a_q, b_q;

  logic [M-1:0] rd_addr;
  logic [N-1:0] rd_data;
  logic         we;
  logic [N-1:0] wr_data;
  logic [N-1:0] alu_res;
  logic         alu_carry;
  logic [N:0]   sum;

  assign op_in   = op_e'(OpCode[OP_LSB +: 3]);
  assign OpReady = (state_q == S_IDLE);

  // Control state: FSM, retire pulses and visible flags.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      error_q  <= error_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  // Next-state decode; NOP and illegal ops retire straight from IDLE.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (OpValid) begin
          accept = 1'b1;
          case (op_in)
            OP_NOP:   done_d  = 1'b1;
            OP_LOADI: state_d = S_WR;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_RD_A;
`ifdef COMPUTER_SHIFT_EN
            OP_SHL:   state_d = S_RD_A;
`endif
            default: begin
              done_d  = 1'b1;
              error_d = 1'b1;
            end
          endcase
        end
      end
      S_RD_A: state_d = S_RD_B;
      S_RD_B: state_d = S_EXEC;
      S_EXEC: state_d = S_WR;
      S_WR: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- accept stage: latch opcode fields; operand capture stages follow ----
  // Opcode fields and operands are pure data and need no reset.
  always_ff @(posedge Clock) begin
    if (accept) begin
      op_q   <= op_in;
      dst_q  <= OpCode[DST_LSB +: M];
      srca_q <= OpCode[SRCA_LSB +: M];
      srcb_q <= OpCode[SRCB_LSB +: M];
      imm_q  <= OpCode[IMM_LSB +: N];
    end
    if (state_q == S_RD_B) begin
      a_q <= rd_data;
    end
    if (state_q == S_EXEC) begin
      b_q <= rd_data;
    end
  end

  // RD_A reads srcA; RD_B reads srcB while srcA data is being captured.
  assign rd_addr = (state_q == S_RD_B) ? srcb_q : srca_q;

  // ---- write stage: ALU result from captured operands ----
  // ALU evaluated in WR from the captured A and B operands.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum       = '0;
    case (op_q)
      OP_ADD: begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = sum[N-1:0];
        alu_carry = sum[N];
      end
      OP_SUB: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
`ifdef COMPUTER_SHIFT_EN
      OP_SHL: begin : shl_blk
        logic [N-1:0]   shamt;
        logic [2*N-1:0] wide;
        shamt     = b_q % N'(N);
        // Bit N of the widened shift is the last bit pushed out of the word.
        wide      = {{N{1'b0}}, a_q} << shamt;
        alu_res   = wide[N-1:0];
        alu_carry = wide[N];
      end
`endif
      default: ;
    endcase
  end

  // Memory write and flag update happen together at the end of WR.
  always_comb begin
    we       = (state_q == S_WR);
    wr_data  = (op_q == OP_LOADI) ? imm_q : alu_res;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    if (we) begin
      result_d = wr_data;
      zero_d   = (wr_data == '0);
      carry_d  = (op_q == OP_LOADI) ? 1'b0 : alu_carry;
    end
  end

  reg_memory #(
    .N (N),
    .M (M)
  ) u_mem (
    .clk_i       (Clock),
    .rst_ni      (ResetN),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .we_i        (we),
    .wr_addr_i   (dst_q),
    .wr_data_i   (wr_data),
    .peek_addr_i (PeekAddr),
    .peek_data_o (PeekData)
  );

  assign Done   = done_q;
  assign Error  = error_q;
  assign Result = result_q;
  assign Zero   = zero_q;
  assign Carry  = carry_q;

endmodule

// File: tb/tb_stream_computer.sv
// Self-checking bench for stream_computer (default N=8, M=2).
// Honours COMPUTER_SHIFT_EN the same way the design does.
module tb_stream_computer;

  localparam int N    = 8;
  localparam int M    = 2;
  localparam int OP_W = 3 + 3 * M + N;
  localparam int MASK = (1 << N) - 1;

  logic            Clock;
  logic            ResetN;
  logic            OpValid;
  logic            OpReady;
  logic [OP_W-1:0] OpCode;
  logic            Done;
  logic            Error;
  logic [N-1:0]    Result;
  logic            Zero;
  logic            Carry;
  logic [M-1:0]    PeekAddr;
  logic [N-1:0]    PeekData;

  int checks = 0;
  int errors = 0;

  // Reference state: memory words and flags.
  int unsigned mm [4];
  int unsigned m_res;
  bit          m_zero;
  bit          m_carry;

  stream_computer #(.N(N), .M(M)) dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .OpValid  (OpValid),
    .OpReady  (OpReady),
    .OpCode   (OpCode),
    .Done     (Done),
    .Error    (Error),
    .Result   (Result),
    .Zero     (Zero),
    .Carry    (Carry),
    .PeekAddr (PeekAddr),
    .PeekData (PeekData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mm[i] = 0;
    m_res   = 0;
    m_zero  = 1'b1;
    m_carry = 1'b0;
  endtask

  // Applies one opcode to the reference state; returns expected Done latency
  // (cycles after the accept edge) and whether it is illegal.
  task automatic model_exec(input int op, input int dst, input int sa, input int sb,
                            input int imm, output int lat, output bit err);
    int unsigned a, b, r, s;
    bit c, wr;
    a = mm[sa]; b = mm[sb]; r = 0; c = 1'b0; wr = 1'b1; err = 1'b0; lat = 5;
    case (op)
      0: begin wr = 1'b0; lat = 1; end
      1: begin r = imm; lat = 2; end
      2: begin r = a + b; c = (r > MASK); r = r & MASK; end
      3: begin r = (a - b) & MASK; c = (a < b); end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: begin
`ifdef COMPUTER_SHIFT_EN
        s = b % N;
        r = (a << s) & MASK;
        c = (s == 0) ? 1'b0 : 1'(((a >> (N - s)) & 1));
`else
        s = 0;
        wr = 1'b0; err = 1'b1; lat = 1;
`endif
      end
    endcase
    if (wr) begin
      mm[dst] = r;
      m_res   = r;
      m_zero  = (r == 0);
      m_carry = c;
    end
  endtask

  task automatic do_reset();
    ResetN  = 1'b0;
    OpValid = 1'b0;
    OpCode  = '0;
    repeat (3) @(posedge Clock);
    #1 ResetN = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      PeekAddr = M'(i);
      #1 check("rst_peek", PeekData, 0);
    end
    check("rst_ready", OpReady, 1);
    check("rst_zero", Zero, 1);
    check("rst_carry", Carry, 0);
    check("rst_done", Done, 0);
    check("rst_result", Result, 0);
  endtask

  function automatic logic [OP_W-1:0] enc(input int op, input int dst, input int sa,
                                          input int sb, input int imm);
    return {op[2:0], dst[M-1:0], sa[M-1:0], sb[M-1:0], imm[N-1:0]};
  endfunction

  // Issues one opcode, waits for Done and checks everything it affects.
  task automatic do_op(input int op, input int dst, input int sa, input int sb, input int imm);
    int lat, cyc;
    bit err;
    cyc = 0;
    while (!OpReady && cyc < 20) begin
      @(posedge Clock); #1; cyc++;
    end
    check("op_ready", OpReady, 1);
    OpCode  = enc(op, dst, sa, sb, imm);
    OpValid = 1'b1;
    @(posedge Clock); #1;
    OpValid = 1'b0;
    model_exec(op, dst, sa, sb, imm, lat, err);
    cyc = 1;
    while (!Done && cyc < 12) begin
      @(posedge Clock); #1; cyc++;
    end
    check($sformatf("lat_op%0d", op), cyc, lat);
    check($sformatf("err_op%0d", op), Error, err);
    check($sformatf("res_op%0d", op), Result, m_res);
    check($sformatf("zero_op%0d", op), Zero, m_zero);
    check($sformatf("carry_op%0d", op), Carry, m_carry);
    PeekAddr = M'(dst);
    #1 check($sformatf("peek_op%0d", op), PeekData, mm[dst]);
    @(posedge Clock); #1;
    check("done_pulse", Done, 0);
  endtask

  task automatic back_to_back();
    logic [OP_W-1:0] codes [3];
    int ops [3][4];
    int unsigned expq [$];
    int idx, dones, busy, extra, lat;
    bit rdy, err;
    ops[0] = '{2, 0, 1, 2};
    ops[1] = '{6, 3, 0, 1};
    ops[2] = '{3, 1, 3, 0};
    for (int i = 0; i < 3; i++) codes[i] = enc(ops[i][0], ops[i][1], ops[i][2], ops[i][3], 0);
    idx = 0; dones = 0; busy = 0; extra = 0;
    OpCode  = codes[0];
    OpValid = 1'b1;
    for (int c = 0; c < 40 && dones < 3; c++) begin
      rdy = OpReady;
      if (Done) begin
        check("b2b_order", Result, (expq.size() > 0) ? expq.pop_front() : 32'hDEAD);
        dones++;
      end
      if (idx < 3 && !rdy) busy++;
      @(posedge Clock); #1;
      if (rdy && idx < 3) begin
        model_exec(ops[idx][0], ops[idx][1], ops[idx][2], ops[idx][3], 0, lat, err);
        expq.push_back(m_res);
        idx++;
        if (idx < 3) OpCode = codes[idx];
        else OpValid = 1'b0;
      end
    end
    OpValid = 1'b0;
    check("b2b_dones", dones, 3);
    check("b2b_busy", busy, 8);
    for (int c = 0; c < 6; c++) begin
      if (Done) extra++;
      @(posedge Clock); #1;
    end
    check("b2b_extra", extra, 0);
    for (int i = 0; i < 4; i++) begin
      PeekAddr = M'(i);
      #1 check("b2b_mem", PeekData, mm[i]);
    end
  endtask

  task automatic reset_mid_op();
    int stray;
    do_op(1, 1, 0, 0, 5);
    do_op(1, 2, 0, 0, 7);
    OpCode  = enc(2, 3, 1, 2, 0);
    OpValid = 1'b1;
    @(posedge Clock); #1;
    OpValid = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    ResetN = 1'b0;
    #2 ResetN = 1'b1;
    model_reset();
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      if (Done) stray++;
      @(posedge Clock); #1;
    end
    check("rmid_nodone", stray, 0);
    PeekAddr = M'(3);
    #1 check("rmid_r3", PeekData, 0);
    check("rmid_zero", Zero, 1);
    do_op(1, 0, 0, 0, 'h5A);
    do_op(2, 3, 0, 0, 0);
  endtask

  initial begin
    PeekAddr = '0;
    do_reset();

    // Directed sequence.
    do_op(1, 1, 0, 0, 'hF0);
    do_op(1, 2, 0, 0, 'h20);
    do_op(2, 3, 1, 2, 0);
    do_op(3, 0, 2, 2, 0);
    do_op(3, 0, 1, 2, 0);
    do_op(3, 0, 2, 1, 0);
    do_op(4, 3, 1, 2, 0);
    do_op(5, 3, 1, 2, 0);
    do_op(6, 3, 1, 1, 0);
    do_op(0, 0, 0, 0, 0);
    do_op(2, 1, 1, 1, 0);
    do_op(1, 0, 0, 0, 'h33);
    do_op(1, 1, 0, 0, 'h81);
    do_op(1, 2, 0, 0, 'h01);
    do_op(7, 0, 1, 2, 0);
    do_op(1, 2, 0, 0, 'h00);
    do_op(7, 3, 1, 2, 0);

    back_to_back();

    // Randomised opcodes.
    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = 1;
      do_op(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, MASK)));
    end

    reset_mid_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
